// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO.
// A byte is pushed, or dropped with an overrun pulse, on the same edge that samples its stop bit.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 417,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            sample;
  logic            push;
  logic            pop;
  logic            push_ok;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Both synchronizer flops reset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign sample = (cnt == '0);
  assign push   = (state == STOP) && sample && rxs;
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (sample) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (sample) begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (sample) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must return high before a new start is armed.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: data_o is the head byte while valid_o=1; the head is consumed on
  // any edge where valid_o && ready_i; ready_i with valid_o=0 has no effect.
  assign valid_o = (count_o != '0);
  assign pop     = valid_o && ready_i;
  assign push_ok = push && ((count_o != FULL_CNT) || pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_o   <= '0;
      overrun_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun_o <= push && !push_ok;
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level event model plus a queue-based FIFO model,
// checked every cycle, with directed scenarios and randomized traffic.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int H     = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] count_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         cyc;
    bit         fe;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] exp_q[$];
  logic [7:0] pop_log[$];
  bit         exp_fe;
  bit         exp_ov;
  int         cyc = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         ready_mode = 0;
  int         pulse_cyc = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model: a frame's outcome lands on the stop-sample edge it was scheduled for;
  // the FIFO is a queue that pops on valid&&ready and accepts a push when it has
  // room or is popping on the same edge.
  always @(posedge clk) begin : model_step
    bit  pop;
    int  sz;
    ev_t ev;
    cyc++;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      evq.delete();
    end else begin
      sz  = exp_q.size();
      pop = (sz > 0) && ready_i;
      if (pop) void'(exp_q.pop_front());
      while (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        if (ev.fe)                      exp_fe = 1'b1;
        else if (sz < DEPTH || pop)     exp_q.push_back(ev.b);
        else                            exp_ov = 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", valid_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_frame_err", frame_err_o, 0);
      chk("rst_overrun", overrun_o, 0);
    end else begin
      chk("valid", valid_o, exp_q.size() > 0);
      chk("count", count_o, exp_q.size());
      if (exp_q.size() > 0) chk("data", data_o, exp_q[0]);
      chk("frame_err", frame_err_o, exp_fe);
      chk("overrun", overrun_o, exp_ov);
      if (frame_err_o) fe_seen++;
      if (overrun_o) ov_seen++;
      if (valid_o && ready_i) pop_log.push_back(data_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    case (ready_mode)
      1:       ready_i = 1'($urandom_range(0, 1));
      2:       ready_i = (cyc + 1 == pulse_cyc);
      default: ;
    endcase
  endtask

  // Stop sample lands at T0 + H + 1 + 9*CPB, with T0 three edges after rx falls.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int tail_low, input int gap);
    ev_t ev;
    ev.cyc = cyc + 3 + H + 1 + 9 * CPB;
    ev.fe  = !stop;
    ev.b   = b;
    evq.push_back(ev);
    if (ready_mode == 2) pulse_cyc = ev.cyc;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    if (tail_low > 0) begin
      rx = 1'b0;
      repeat (tail_low) tick();
    end
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic pop_one(input logic [7:0] exp, input string name);
    chk({name, "_valid"}, valid_o, 1);
    chk(name, data_o, exp);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int base_pop;
    int base_fe;
    int base_ov;
    int bc;
    logic [7:0] b;
    logic [7:0] partial;
    bit good;
    int gap;
    logic [7:0] b2b [4];
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h3C;

    repeat (3) tick();
    chk("reset_valid", valid_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_busy", busy_o, 0);
    rst_n = 1'b1;
    repeat (CPB) tick();

    // single byte
    send_frame(8'hA5, 1'b1, 0, 4);
    chk("single_valid", valid_o, 1);
    chk("single_data", data_o, 8'hA5);
    chk("single_count", count_o, 1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("single_pop_valid", valid_o, 0);
    chk("single_pop_count", count_o, 0);

    // back-to-back with ready held high
    base_pop = pop_log.size();
    base_fe  = fe_seen;
    base_ov  = ov_seen;
    ready_i  = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, 0, (i == 3) ? 4 : 0);
    ready_i = 1'b0;
    chk("b2b_pop_count", pop_log.size() - base_pop, 4);
    for (int i = 0; i < 4; i++)
      if (pop_log.size() > base_pop + i) chk("b2b_pop_data", pop_log[base_pop + i], b2b[i]);
    chk("b2b_frame_err", fe_seen - base_fe, 0);
    chk("b2b_overrun", ov_seen - base_ov, 0);

    // overrun: fifth byte dropped
    base_ov = ov_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, (i == 5) ? 4 : 0);
    chk("ovr_count", count_o, 4);
    chk("ovr_pulses", ov_seen - base_ov, 1);
    for (int i = 1; i <= 4; i++) pop_one(8'(i), "ovr_drain");
    chk("ovr_empty", count_o, 0);

    // full FIFO with a pop on the push edge: no overrun
    base_ov = ov_seen;
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 0, 0);
    ready_mode = 2;
    send_frame(8'h15, 1'b1, 0, 4);
    ready_mode = 0;
    ready_i    = 1'b0;
    chk("ovr2_count", count_o, 4);
    chk("ovr2_pulses", ov_seen - base_ov, 0);
    for (int i = 2; i <= 5; i++) pop_one(8'h10 + 8'(i), "ovr2_drain");

    // framing error followed by a 40-bit break, then a clean byte
    base_fe = fe_seen;
    send_frame(8'h81, 1'b0, 40 * CPB, CPB);
    chk("fe_pulses", fe_seen - base_fe, 1);
    chk("fe_count", count_o, 0);
    send_frame(8'h42, 1'b1, 0, 4);
    chk("fe_next_count", count_o, 1);
    pop_one(8'h42, "fe_next_data");

    // 4-cycle glitch
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i == 4) rx = 1'b1;
      tick();
      if (busy_o) bc++;
    end
    chk("glitch_busy_window", (bc > 0) && (bc <= 10), 1);
    chk("glitch_busy_end", busy_o, 0);
    chk("glitch_count", count_o, 0);

    // asynchronous reset during data bit 3 with two bytes queued
    send_frame(8'h31, 1'b1, 0, 0);
    send_frame(8'h32, 1'b1, 0, 4);
    chk("rst_mid_queued", count_o, 2);
    partial = 8'h99;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (CPB) tick();
    end
    rx = partial[3];
    repeat (H) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_count", count_o, 0);
    chk("rst_mid_data", data_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    tick();
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (CPB) tick();
    send_frame(8'h7E, 1'b1, 0, 4);
    chk("rst_after_count", count_o, 1);
    pop_one(8'h7E, "rst_after_data");

    // randomized traffic with random consumer back-pressure
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      gap  = $urandom_range(0, 2 * CPB);
      if (!good && gap < 4) gap = 4;
      send_frame(b, good, 0, gap);
    end
    ready_mode = 0;
    ready_i    = 1'b1;
    repeat (DEPTH + 2) tick();
    ready_i = 1'b0;
    tick();
    chk("final_empty", count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

8N1 UART receiver with a first-word-fall-through receive FIFO, clocked from the 48 MHz user clock domain. It is the receiving end for the UART stream our user project drives on `uart_tx` (io 33) and feeds the byte stream to on-chip consumers over a valid/ready interface. It is used as an on-chip monitor/loopback sink and as the receive path for future Wishbone-visible UART logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, 417: clock cycles per bit (48 MHz / 115200 baud); minimum 8.
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.

Ports:
- `clk` in 1: single clock; everything is synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `data_o` out 8: byte at the FIFO head; valid only while `valid_o`=1.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer accepts the head byte; pop when `valid_o && ready_i`.
- `count_o` out $clog2(DEPTH)+1: current FIFO occupancy.
- `busy_o` out 1: FSM not in IDLE.
- `frame_err_o` out 1: one-cycle pulse when a stop bit samples 0.
- `overrun_o` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1). All decisions use the synchronized value `rxs`.
- Bit-period counter: counts down from its load value to 0; a sample is taken when it reaches 0.
- FSM states:
  - IDLE: on `rxs`=0, load the counter with `CLKS_PER_BIT/2` (integer floor) and go to START.
  - START: at the sample point, `rxs`=1 means a glitch, so return to IDLE with no pulse. `rxs`=0 goes to DATA with the counter loaded to `CLKS_PER_BIT-1` and the bit index set to 0.
  - DATA: at each sample, shift `rxs` into the shift register LSB-first. After bit index 7, go to STOP with the counter reloaded.
  - STOP: at the sample point, `rxs`=1 means push the byte and go to IDLE. `rxs`=0 means pulse `frame_err_o`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`=1, then go to IDLE. This prevents a break condition from being treated as repeated start bits.
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `data_o` always presents the mem[rd_ptr] head entry.
  - A push is accepted if `count_o` < DEPTH, or if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave `count_o` unchanged, with both pointers advancing.
  - A push refused while full drops the byte and pulses `overrun_o`. FIFO contents are unchanged.
  - A pop with `valid_o`=0 is ignored.
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE, any partial byte is discarded, and the FIFO is emptied.
  - Output reset values: `valid_o`=0, `data_o`=0, `count_o`=0, `busy_o`=0, `frame_err_o`=0, `overrun_o`=0.
  - After `rst_n` is released while `rx` is low, the block sees `rxs`=0 as a start edge. Frame resync is the sender's responsibility.

## Timing
- Cycle T0 is the first clock edge at which `rxs`=0 is seen in IDLE.
- START sample occurs at T0 + `CLKS_PER_BIT/2` + 1.
- Data bit k is sampled at the START sample + (k+1)·`CLKS_PER_BIT`. The stop bit is sampled at the START sample + 9·`CLKS_PER_BIT`.
- `valid_o` rises, and `count_o` increments, on the cycle after the stop sample. The same timing applies to the `frame_err_o` and `overrun_o` pulses.
- Pin-to-`rxs` latency is 2 cycles.
- Back-to-back frames with 1 stop bit are received with no loss: the FSM is in IDLE one cycle after the stop sample, which is mid-stop-bit.
- Pop is combinational on `ready_i`. `data_o` and `valid_o` update on the next edge.
- Minimum pulse width for `frame_err_o` and `overrun_o` is exactly 1 cycle.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `DEPTH`=4 unless stated.
- **Single byte:** send 0xA5 with `ready_i`=0.
  - `valid_o` rises 1 cycle after the stop sample with `data_o`=0xA5 and `count_o`=1.
  - Assert `ready_i` for 1 cycle: `valid_o`=0 and `count_o`=0.
- **Back-to-back:** send 0x00, 0xFF, 0x55, 0x3C with no idle gap and `ready_i`=1 throughout.
  - Exactly 4 pops occur, in order, with no `frame_err_o` or `overrun_o`.
- **Overrun:** send 5 bytes 0x01..0x05 with `ready_i`=0.
  - `count_o` reaches 4 and `overrun_o` pulses once at the 5th stop sample.
  - Drain returns 0x01..0x04.
  - Second part: with the FIFO full and `ready_i`=1 exactly on the cycle byte 5 is pushed, no overrun occurs and `count_o` stays 4.
- **Framing/break:** send 0x81 with the stop bit low, then hold `rx` low for 40 bit times, then release it high.
  - `frame_err_o` pulses exactly once and `count_o` stays 0.
  - A following 0x42 is received correctly.
- **Glitch:** drive a 4-cycle low pulse on idle `rx`.
  - FSM returns to IDLE, `busy_o` is high for at most 10 cycles, and nothing is pushed.
- **Async reset mid-frame:** assert `rst_n`=0 during data bit 3 while 2 bytes are queued.
  - Outputs immediately show `valid_o`=0 and `count_o`=0.
  - After release, and with `rx` idle high for 1 bit time, 0x7E is received correctly.
